// File: rtl/dcm_lock_supervisor_if.sv
// rtl/dcm_lock_supervisor_if.sv - control/status bundle between a DCM lock supervisor and its host
interface dcm_lock_supervisor_if;
  logic       enable_i;
  logic       dcm_locked_i;
  logic       restart_i;
  logic       dcm_reset_o;
  logic       clk_ok_o;
  logic       lost_lock_o;
  logic       fail_o;
  logic [3:0] retry_count_o;

  modport master (
    output enable_i,
    output dcm_locked_i,
    output restart_i,
    input  dcm_reset_o,
    input  clk_ok_o,
    input  lost_lock_o,
    input  fail_o,
    input  retry_count_o
  );

  modport slave (
    input  enable_i,
    input  dcm_locked_i,
    input  restart_i,
    output dcm_reset_o,
    output clk_ok_o,
    output lost_lock_o,
    output fail_o,
    output retry_count_o
  );
endinterface

// File: rtl/dcm_lock_supervisor.sv
// rtl/dcm_lock_supervisor.sv - DCM reset sequencing, lock qualification and bounded retry supervisor
module dcm_lock_supervisor #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  dcm_lock_supervisor_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_FAIL
  } state_t;

  // Terminal counts are "last cycle" values: the counter starts at 0 on entry.
  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [3:0]  retry_cnt;
  logic [3:0]  retry_nxt;
  logic        retry_evt;
  logic        lost_nxt;
  logic        sync_meta;
  logic        locked;
  logic        dcm_reset_q;
  logic        clk_ok_q;
  logic        lost_lock_q;
  logic        fail_q;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    retry_evt = 1'b0;
    lost_nxt  = 1'b0;
    if (!bus.enable_i) begin
      state_nxt = S_IDLE;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_IDLE:      state_nxt = S_RESET;
        S_RESET:     if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (locked)                    state_nxt = S_STABLE;
          else if (cnt == TIMEOUT_LAST)  retry_evt = 1'b1;
        end
        S_STABLE: begin
          if (!locked) begin
            retry_evt = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = S_LOCKED;
            retry_nxt = 4'd0;
          end
        end
        S_LOCKED: begin
          if (!locked) begin
            state_nxt = S_RESET;
            lost_nxt  = 1'b1;
          end
        end
        S_FAIL: begin
          if (bus.restart_i) begin
            state_nxt = S_RESET;
            retry_nxt = 4'd0;
          end
        end
        default:     state_nxt = S_IDLE;
      endcase
      // Any failure path funnels through here, so a lock loss coinciding with a timeout counts once.
      if (retry_evt) begin
        if (retry_cnt == RETRY_LIMIT) begin
          state_nxt = S_FAIL;
        end else begin
          state_nxt = S_RESET;
          retry_nxt = retry_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_meta   <= 1'b0;
      locked      <= 1'b0;
      state       <= S_IDLE;
      cnt         <= 16'd0;
      retry_cnt   <= 4'd0;
      dcm_reset_q <= 1'b1;
      clk_ok_q    <= 1'b0;
      lost_lock_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync_meta <= bus.dcm_locked_i;
      locked    <= sync_meta;
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (state_nxt != state) begin
        cnt <= 16'd0;
      end else if (state == S_RESET || state == S_WAIT_LOCK || state == S_STABLE) begin
        cnt <= cnt + 16'd1;
      end
      // Outputs decode the next state so they change on the same edge as the state register.
      dcm_reset_q <= (state_nxt == S_IDLE) || (state_nxt == S_RESET) || (state_nxt == S_FAIL);
      clk_ok_q    <= (state_nxt == S_LOCKED);
      fail_q      <= (state_nxt == S_FAIL);
      lost_lock_q <= lost_nxt;
    end
  end

  assign bus.dcm_reset_o   = dcm_reset_q;
  assign bus.clk_ok_o      = clk_ok_q;
  assign bus.lost_lock_o   = lost_lock_q;
  assign bus.fail_o        = fail_q;
  assign bus.retry_count_o = retry_cnt;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb/tb_dcm_lock_supervisor.sv - directed vector bench for dcm_lock_supervisor
module tb_dcm_lock_supervisor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dcm_lock_supervisor_if bus ();

  dcm_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied at a falling edge, n rising edges run, outputs sampled at the next falling edge.
  typedef struct packed {
    logic       en;
    logic       lk;
    logic       rs;
    logic [7:0] n;
    logic       dr;
    logic       ok;
    logic       ll;
    logic       fl;
    logic [3:0] rc;
  } vec_t;

  vec_t vecs [32];

  function automatic logic [7:0] outs();
    return {bus.dcm_reset_o, bus.clk_ok_o, bus.lost_lock_o, bus.fail_o, bus.retry_count_o};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {rst,ok,lost,fail,retry}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.enable_i     = 1'b0;
    bus.dcm_locked_i = 1'b0;
    bus.restart_i    = 1'b0;

    //              en    lk    rs    n      dr    ok    ll    fl    rc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd7,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'd19, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'd3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'd19, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 8'd19, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 8'd5,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[27] = '{1'b1, 1'b1, 1'b0, 8'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[28] = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[29] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[30] = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[31] = '{1'b0, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

    @(negedge clk);
    @(negedge clk);
    check("reset_state", outs(), 8'h80);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.enable_i     = vecs[i].en;
      bus.dcm_locked_i = vecs[i].lk;
      bus.restart_i    = vecs[i].rs;
      edges(int'(vecs[i].n));
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].dr, vecs[i].ok, vecs[i].ll, vecs[i].fl, vecs[i].rc});
    end

    // Async reset while LOCKED, then exact relock latency from IDLE.
    bus.enable_i     = 1'b1;
    bus.dcm_locked_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      found = bus.clk_ok_o;
    end
    check("reach_locked", {7'd0, found}, 8'h01);
    rst = 1'b1;
    #2;
    check("async_reset_locked", outs(), 8'h80);
    @(negedge clk);
    rst = 1'b0;
    edges(13);
    check("relock_before", outs(), 8'h00);
    edges(1);
    check("relock_at_14", outs(), 8'h40);

    // Disable while lock is lost in LOCKED: disable wins, no lost_lock pulse.
    bus.dcm_locked_i = 1'b0;
    edges(2);
    check("locked_pre_disable", outs(), 8'h40);
    bus.enable_i = 1'b0;
    edges(1);
    check("disable_over_loss", outs(), 8'h80);

    // Reach FAIL, then disable together with restart: disable must win.
    bus.enable_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      found = bus.fail_o;
    end
    check("reach_fail", outs(), 8'h92);
    bus.enable_i  = 1'b0;
    bus.restart_i = 1'b1;
    edges(1);
    check("disable_over_restart", outs(), 8'h80);
    bus.enable_i  = 1'b1;
    bus.restart_i = 1'b0;
    edges(4);
    check("from_idle_reset", outs(), 8'h80);
    edges(1);
    check("from_idle_wait", outs(), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
